// File: rtl/exp_dispatch_pkg.sv
// Shared types and helpers for the exp/distance engine job dispatcher.
// State encoding, timeout counter width and a clog2 for timer sizing.
package exp_dispatch_pkg;

  localparam int TO_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_CAPTURE,
    S_RESP,
    S_RECOVER
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Loadable up-counter with clear, enable and terminal-count flag.
// Shared between the start-hold count and the done watchdog.
module dispatch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear beats load beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (ld) cnt_d = ld_val;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == limit);

endmodule

// File: rtl/exp_job_dispatcher.sv
// Start/done sequencer for the exp/distance engine with a watchdog
// that pulses the engine reset and returns an error response.
module exp_job_dispatcher
  import exp_dispatch_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [DATA_W-1:0]   job_x,
  output logic [DATA_W-1:0]   eng_x,
  output logic                eng_s,
  input  logic                eng_s_done,
  input  logic [DATA_W-1:0]   eng_result,
  output logic                eng_rst,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic                res_err,
  output logic [TO_CNT_W-1:0] timeout_cnt
);

  localparam int TMAX =
    (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int TW = clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LIM = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LIM = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   eng_x_q, eng_x_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  logic          tmr_clr;
  logic          tmr_en;
  logic [TW-1:0] tmr_lim;
  logic [TW-1:0] tmr_cnt;
  logic          tmr_tc;

  assign tmr_lim = (state_q == S_START) ? HOLD_LIM : WAIT_LIM;

  dispatch_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (tmr_en),
    .limit  (tmr_lim),
    .cnt    (tmr_cnt),
    .tc     (tmr_tc)
  );

  // next-state and datapath updates; done wins over watchdog expiry
  always_comb begin
    state_d    = state_q;
    eng_x_d    = eng_x_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    to_cnt_d   = to_cnt_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          eng_x_d = job_x;
          tmr_clr = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          state_d = S_WAIT_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (eng_s_done)  state_d = S_CAPTURE;
        else if (tmr_tc) state_d = S_RECOVER;
        else             tmr_en  = 1'b1;
      end
      S_CAPTURE: begin
        res_data_d = eng_result;
        res_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      S_RECOVER: begin
        res_data_d = '0;
        res_err_d  = 1'b1;
        if (to_cnt_q != {TO_CNT_W{1'b1}})
          to_cnt_d = to_cnt_q + 1'b1;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      eng_x_q    <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      eng_x_q    <= eng_x_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign job_ready   = (state_q == S_IDLE);
  assign eng_s       = (state_q == S_START);
  assign eng_rst     = (state_q == S_RECOVER);
  assign res_valid   = (state_q == S_RESP);
  assign eng_x       = eng_x_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;
  assign timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_exp_job_dispatcher.sv
// Directed self-checking bench for exp_job_dispatcher.
// START_CYCLES=2, TIMEOUT=16.
module tb_exp_job_dispatcher;

  localparam int DW = 32;
  localparam int SC = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid;
  logic          job_ready;
  logic [DW-1:0] job_x;
  logic [DW-1:0] eng_x;
  logic          eng_s;
  logic          eng_s_done;
  logic [DW-1:0] eng_result;
  logic          eng_rst;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_err;
  logic [7:0]    timeout_cnt;

  int checks = 0;
  int errors = 0;

  exp_job_dispatcher #(
    .DATA_W      (DW),
    .START_CYCLES(SC),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_x      (job_x),
    .eng_x      (eng_x),
    .eng_s      (eng_s),
    .eng_s_done (eng_s_done),
    .eng_result (eng_result),
    .eng_rst    (eng_rst),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer a job, returns sampled just after the edge where eng_s falls
  task automatic launch(input logic [DW-1:0] x);
    job_x     = x;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    for (int i = 0; i < SC; i++) tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    job_valid  = 1'b1;
    job_x      = 32'hDEAD_0001;
    eng_s_done = 1'b0;
    eng_result = '0;
    res_ready  = 1'b0;
    tick();
    tick();
    checks++;
    if (eng_s !== 1'b0 || eng_rst !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: s=%b rst=%b rv=%b want 0 0 0",
               eng_s, eng_rst, res_valid);
    end
    checks++;
    if (res_err !== 1'b0 || res_data !== '0 || eng_x !== '0) begin
      errors++;
      $display("FAIL reset_data: err=%b data=%h x=%h want 0",
               res_err, res_data, eng_x);
    end
    checks++;
    if (timeout_cnt !== 8'd0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_misc: tcnt=%0d jr=%b want 0 1",
               timeout_cnt, job_ready);
    end
    job_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_single_job();
    job_x     = 32'h0000_0010;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    checks++;
    if (eng_s !== 1'b1 || eng_x !== 32'h10 || job_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: s=%b x=%h jr=%b want 1 10 0",
               eng_s, eng_x, job_ready);
    end
    tick();
    checks++;
    if (eng_s !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: s=%b want 1", eng_s);
    end
    tick();
    checks++;
    if (eng_s !== 1'b0) begin
      errors++;
      $display("FAIL single_fall: s=%b want 0", eng_s);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (eng_s !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_wait%0d: s=%b rv=%b want 0 0",
                 i, eng_s, res_valid);
      end
    end
    eng_s_done = 1'b1;
    eng_result = 32'h1234_5678;
    tick();
    eng_s_done = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: rv=%b want 0", res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h1234_5678 ||
        res_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: rv=%b data=%h err=%b want 1 12345678 0",
               res_valid, res_data, res_err);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_release: rv=%b jr=%b want 0 1",
               res_valid, job_ready);
    end
  endtask

  task automatic test_backpressure();
    launch(32'h0000_0022);
    tick();
    tick();
    eng_s_done = 1'b1;
    eng_result = 32'hCAFE_F00D;
    tick();
    eng_s_done = 1'b0;
    tick();
    job_x     = 32'h0000_0099;
    job_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'hCAFE_F00D ||
          job_ready !== 1'b0 || eng_x !== 32'h22 || eng_s !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b d=%h jr=%b x=%h s=%b",
                 i, res_valid, res_data, job_ready, eng_x, eng_s);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    job_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1 || eng_x !== 32'h22) begin
      errors++;
      $display("FAIL bp_release: rv=%b jr=%b x=%h want 0 1 22",
               res_valid, job_ready, eng_x);
    end
    tick();
  endtask

  task automatic test_timeout();
    launch(32'h0000_0033);
    for (int i = 1; i < TO; i++) begin
      tick();
      checks++;
      if (eng_rst !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL to_early%0d: rst=%b rv=%b want 0 0",
                 i, eng_rst, res_valid);
      end
    end
    tick();
    checks++;
    if (eng_rst !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: rst=%b rv=%b want 1 0", eng_rst, res_valid);
    end
    tick();
    checks++;
    if (eng_rst !== 1'b0 || res_valid !== 1'b1 || res_err !== 1'b1 ||
        res_data !== '0 || timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL to_resp: rst=%b rv=%b err=%b d=%h tc=%0d",
               eng_rst, res_valid, res_err, res_data, timeout_cnt);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_coincident();
    launch(32'h0000_0044);
    for (int i = 1; i < TO; i++) tick();
    eng_s_done = 1'b1;
    eng_result = 32'hA5A5_A5A5;
    tick();
    eng_s_done = 1'b0;
    checks++;
    if (eng_rst !== 1'b0) begin
      errors++;
      $display("FAIL coinc_rst: rst=%b want 0", eng_rst);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b0 ||
        res_data !== 32'hA5A5_A5A5 || timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL coinc_resp: rv=%b err=%b d=%h tc=%0d",
               res_valid, res_err, res_data, timeout_cnt);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    eng_s_done = 1'b1;
    eng_result = 32'h5555_5555;
    tick();
    tick();
    eng_s_done = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || eng_s !== 1'b0 || res_valid !== 1'b0 ||
        res_data !== 32'hA5A5_A5A5 || timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL spurious: jr=%b s=%b rv=%b d=%h tc=%0d",
               job_ready, eng_s, res_valid, res_data, timeout_cnt);
    end
  endtask

  task automatic test_reset_mid();
    launch(32'h0000_0055);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (eng_s !== 1'b0 || res_valid !== 1'b0 || job_ready !== 1'b1 ||
        eng_rst !== 1'b0 || eng_x !== '0 || timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: s=%b rv=%b jr=%b rst=%b x=%h tc=%0d",
               eng_s, res_valid, job_ready, eng_rst, eng_x, timeout_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    launch(32'h0000_0077);
    tick();
    eng_s_done = 1'b1;
    eng_result = 32'h0BAD_BEEF;
    tick();
    eng_s_done = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0BAD_BEEF ||
        res_err !== 1'b0 || eng_x !== 32'h77) begin
      errors++;
      $display("FAIL rst_after: rv=%b d=%h err=%b x=%h",
               res_valid, res_data, res_err, eng_x);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      launch(n);
      for (int k = 0; k < TO + 8 && res_valid !== 1'b1; k++) tick();
      if (res_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL sat_wait%0d: rv=%b want 1", n, res_valid);
      end
      if (n == 99) begin
        checks++;
        if (timeout_cnt !== 8'd100) begin
          errors++;
          $display("FAIL sat_mid: tc=%0d want 100", timeout_cnt);
        end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    checks++;
    if (timeout_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: tc=%0d want 255", timeout_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_backpressure();
    test_timeout();
    test_coincident();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_job_dispatcher.md
# exp_job_dispatcher

Initiator-side sequencer for the exp/distance compute engine's start/done handshake. It accepts operand jobs from an upstream valid/ready port and drives the engine's level-sensitive start line: raise, hold, release. It then waits for the engine's one-cycle done pulse, captures the engine's registered result and returns it downstream on a valid/ready port. A watchdog recovers a hung engine by pulsing the engine reset and returning an error-tagged response.

## Interface
Parameters:
- DATA_W, 32, width of operand and result
- START_CYCLES, 2, cycles the start line is held high (≥1)
- TIMEOUT, 1024, cycles to wait for done after start release (≥4)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- job_valid  in  1  upstream job offered
- job_ready  out  1  dispatcher can accept a job
- job_x  in  DATA_W  operand
- eng_x  out  DATA_W  operand to engine, registered at acceptance
- eng_s  out  1  engine start line
- eng_s_done  in  1  engine done pulse, one cycle
- eng_result  in  DATA_W  engine result register output
- eng_rst  out  1  engine recovery reset, active-high, one-cycle pulse
- res_valid  out  1  response available
- res_ready  in  1  downstream accepts response
- res_data  out  DATA_W  result
- res_err  out  1  response is a timeout error
- timeout_cnt  out  8  saturating count of timeouts

## Operation
- States: IDLE, START, WAIT_DONE, CAPTURE, RESP, RECOVER.
- IDLE: job_ready=1. On job_valid, latch job_x into eng_x, clear the hold counter, go to START.
- START: eng_s=1. After START_CYCLES cycles go to WAIT_DONE. The engine requires start to fall before it computes.
- WAIT_DONE: eng_s=0, timer runs. On eng_s_done go to CAPTURE. When the timer reaches TIMEOUT-1 without done, go to RECOVER.
- CAPTURE: sample eng_result into res_data, res_err=0, go to RESP. The engine loads its result register on the same edge it asserts done, so the value is stable one cycle later.
- RESP: res_valid=1. On res_ready go to IDLE.
- RECOVER: eng_rst=1 for one cycle, res_data=0, res_err=1, timeout_cnt increments (saturates at 255), go to RESP.
- eng_s_done outside WAIT_DONE is ignored.
- eng_s_done in the same cycle the timer expires counts as done; no timeout is recorded.
- eng_x holds its value until the next acceptance.

## Timing
- Reset values: state IDLE, eng_s=0, eng_rst=0, res_valid=0, res_err=0, res_data=0, eng_x=0, timeout_cnt=0. job_ready reads 1 but no job is accepted while rst_n is low.
- Acceptance at edge T: eng_s is high from T through T+START_CYCLES-1, and low from T+START_CYCLES.
- eng_s_done sampled high at edge D: res_data is loaded at D+1, and res_valid is high from D+1 until the edge where res_ready is sampled high.
- Timeout: eng_s falls at edge F. The RECOVER transition happens at F+TIMEOUT, eng_rst is high for the following cycle, and res_valid follows one cycle later.
- Throughput: at most one outstanding job; job_ready=0 from acceptance until RESP completes.
- res_ready held high returns to IDLE in one cycle, so back-to-back jobs are spaced by at least START_CYCLES+3 cycles plus engine latency.
- rst_n asserted mid-operation: immediate return to reset values, in-flight job dropped, eng_rst not driven. The engine is reset by its own system reset.

## Structure
- Package exp_dispatch_pkg: state enum, the width of timeout_cnt, and a clog2 helper for timer widths.
- One sub-module, dispatch_timer: loadable up-counter with clear, enable and terminal-count flag. The top instantiates it once and reuses it for the START hold count and the WAIT_DONE watchdog.

## Test plan
- Single job: job_x=0x0000_0010; engine model asserts done 7 cycles after eng_s falls with eng_result=0x1234_5678 → eng_s high exactly 2 cycles; res_valid one cycle after done; res_data=0x1234_5678, res_err=0.
- Backpressure: res_ready held low 5 cycles → res_valid and res_data stable, job_ready=0 throughout; job_valid offered meanwhile is not accepted.
- Timeout: engine never asserts done, TIMEOUT=16 → eng_rst pulse 16 cycles after eng_s falls; response res_err=1, res_data=0; timeout_cnt=1.
- Done coincident with timer expiry → normal response with res_err=0 and timeout_cnt unchanged. A spurious eng_s_done injected in IDLE causes no state change.
- Reset mid-job: rst_n dropped during WAIT_DONE → eng_s=0, res_valid=0 immediately. After release, a new job completes normally.
- Saturation: 260 forced timeouts → timeout_cnt=255.
